// File: rtl/iomem_ctrl_pkg.sv
// Shared types and constants for the PicoSoC iomem sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, slot index width, default response words, slot numbers.
package iomem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Slot index is addr[11:8], so at most 16 slots.
  localparam int SLOT_W = 4;

  localparam logic [31:0] DEF_UNMAP_DATA = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_TMO_DATA   = 32'hDEAD_BEEF;

  localparam logic [SLOT_W-1:0] SLOT_GPIO = 4'd0;
  localparam logic [SLOT_W-1:0] SLOT_RNG  = 4'd1;
  localparam logic [SLOT_W-1:0] SLOT_RAM  = 4'd2;

endpackage

// File: rtl/iomem_decode.sv
// Address decode: one slot per 256-byte window above BASE_ADDR[31:12].
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the address.
// Ports: i_addr_hi = addr[31:8]; o_hit = address maps to an existing slot; o_slot = addr[11:8].
module iomem_decode
  import iomem_ctrl_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic [23:0]       i_addr_hi,
  output logic              o_hit,
  output logic [SLOT_W-1:0] o_slot
);

  logic w_base_match;
  logic w_slot_ok;

  assign w_base_match = (i_addr_hi[23:4] == BASE_ADDR[31:12]);
  // Windows at or above NUM_SLV inside the region are unmapped.
  assign w_slot_ok    = ({28'd0, i_addr_hi[3:0]} < 32'(NUM_SLV));
  assign o_hit        = w_base_match && w_slot_ok;
  assign o_slot       = i_addr_hi[3:0];

endmodule

// File: rtl/iomem_ctrl.sv
// Registered sequencer for PicoSoC iomem onto NUM_SLV peripheral slots, with unmapped response and timeout.
// Latency: unmapped 1 cycle, hit 2 cycles + slave wait, worst case TIMEOUT_CYC+1 cycles.
// Backpressure: slave stalls via slv_ready_i of the selected slot; CPU holds iomem_valid_i until iomem_ready_o.
// Ports: iomem_* = CPU side; slv_* = shared slave bus (one-hot select, level strobes, flat read data).
// Option: define IOMEM_CTRL_ERRLOG_EN to add err_addr_o / err_cnt_o (last failing address, saturating count).
module iomem_ctrl
  import iomem_ctrl_pkg::*;
#(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] UNMAP_DATA  = DEF_UNMAP_DATA,
  parameter logic [31:0] TMO_DATA    = DEF_TMO_DATA
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iomem_valid_i,
  output logic                  iomem_ready_o,
  input  logic [3:0]            iomem_wstrb_i,
  input  logic [31:0]           iomem_addr_i,
  input  logic [31:0]           iomem_wdata_i,
  output logic [31:0]           iomem_rdata_o,
  output logic [NUM_SLV-1:0]    slv_sel_o,
  output logic                  slv_we_o,
  output logic                  slv_re_o,
  output logic [3:0]            slv_wstrb_o,
  output logic [7:0]            slv_addr_o,
  output logic [31:0]           slv_wdata_o,
  input  logic [32*NUM_SLV-1:0] slv_rdata_i,
  input  logic [NUM_SLV-1:0]    slv_ready_i
`ifdef IOMEM_CTRL_ERRLOG_EN
  ,
  output logic [31:0]           err_addr_o,
  output logic [7:0]            err_cnt_o
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic [NUM_SLV-1:0] r_sel;
  logic               r_we;
  logic               r_re;
  logic [3:0]         r_wstrb;
  logic [7:0]         r_addr;
  logic [31:0]        r_wdata;

  logic               w_hit;
  logic [SLOT_W-1:0]  w_slot;
  logic               w_slv_ready;
  logic [31:0]        w_slv_rdata;

`ifdef IOMEM_CTRL_ERRLOG_EN
  logic [31:0]        r_req_addr;
  logic [31:0]        r_err_addr;
  logic [7:0]         r_err_cnt;
`endif

  iomem_decode #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .i_addr_hi (iomem_addr_i[31:8]),
    .o_hit     (w_hit),
    .o_slot    (w_slot)
  );

  // r_sel is one-hot for the active slot, so masking ignores every other slot's ready.
  assign w_slv_ready = |(slv_ready_i & r_sel);

  always_comb begin
    w_slv_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_sel[k]) w_slv_rdata = slv_rdata_i[32*k +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef IOMEM_CTRL_ERRLOG_EN
      r_req_addr <= '0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
`endif
    end else begin
      // Completion is a single-cycle pulse and read data is zero outside it.
      r_ready <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (iomem_valid_i && !r_ready) begin
            r_addr  <= iomem_addr_i[7:0];
            r_wdata <= iomem_wdata_i;
            r_wstrb <= iomem_wstrb_i;
`ifdef IOMEM_CTRL_ERRLOG_EN
            r_req_addr <= iomem_addr_i;
`endif
            if (w_hit) begin
              r_sel   <= NUM_SLV'(1) << w_slot;
              r_we    <= |iomem_wstrb_i;
              r_re    <= ~|iomem_wstrb_i;
              r_state <= ACCESS;
            end else begin
              r_ready <= 1'b1;
              r_rdata <= (|iomem_wstrb_i) ? 32'd0 : UNMAP_DATA;
              r_state <= RESP;
`ifdef IOMEM_CTRL_ERRLOG_EN
              r_err_addr <= iomem_addr_i;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
`endif
            end
          end
        end
        ACCESS: begin
          if (w_slv_ready || (r_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
            r_ready <= 1'b1;
            if (r_we)             r_rdata <= 32'd0;
            else if (w_slv_ready) r_rdata <= w_slv_rdata;
            else                  r_rdata <= TMO_DATA;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_cnt   <= '0;
            r_state <= RESP;
`ifdef IOMEM_CTRL_ERRLOG_EN
            if (!w_slv_ready) begin
              r_err_addr <= r_req_addr;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign iomem_ready_o = r_ready;
  assign iomem_rdata_o = r_rdata;
  assign slv_sel_o     = r_sel;
  assign slv_we_o      = r_we;
  assign slv_re_o      = r_re;
  assign slv_wstrb_o   = r_wstrb;
  assign slv_addr_o    = r_addr;
  assign slv_wdata_o   = r_wdata;
`ifdef IOMEM_CTRL_ERRLOG_EN
  assign err_addr_o    = r_err_addr;
  assign err_cnt_o     = r_err_cnt;
`endif

endmodule

// File: tb/tb_iomem_ctrl.sv
// Directed bench for iomem_ctrl: hit reads/writes with wait states, unmapped, timeout, reset abort, foreign ready.
// Latency: expected completion cycle counts are hand-derived from the sequencer timing.
// Backpressure: slave model asserts ready after a per-slot number of wait cycles, or never.
module tb_iomem_ctrl;

  localparam int NUM_SLV = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  iomem_valid_i;
  logic                  iomem_ready_o;
  logic [3:0]            iomem_wstrb_i;
  logic [31:0]           iomem_addr_i;
  logic [31:0]           iomem_wdata_i;
  logic [31:0]           iomem_rdata_o;
  logic [NUM_SLV-1:0]    slv_sel_o;
  logic                  slv_we_o;
  logic                  slv_re_o;
  logic [3:0]            slv_wstrb_o;
  logic [7:0]            slv_addr_o;
  logic [31:0]           slv_wdata_o;
  logic [32*NUM_SLV-1:0] slv_rdata_i;
  logic [NUM_SLV-1:0]    slv_ready_i;
`ifdef IOMEM_CTRL_ERRLOG_EN
  logic [31:0]           err_addr_o;
  logic [7:0]            err_cnt_o;
`endif

  iomem_ctrl #(
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (32'h0300_0000),
    .TIMEOUT_CYC (64),
    .UNMAP_DATA  (32'hFFFF_FFFF),
    .TMO_DATA    (32'hDEAD_BEEF)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .iomem_valid_i (iomem_valid_i),
    .iomem_ready_o (iomem_ready_o),
    .iomem_wstrb_i (iomem_wstrb_i),
    .iomem_addr_i  (iomem_addr_i),
    .iomem_wdata_i (iomem_wdata_i),
    .iomem_rdata_o (iomem_rdata_o),
    .slv_sel_o     (slv_sel_o),
    .slv_we_o      (slv_we_o),
    .slv_re_o      (slv_re_o),
    .slv_wstrb_o   (slv_wstrb_o),
    .slv_addr_o    (slv_addr_o),
    .slv_wdata_o   (slv_wdata_o),
    .slv_rdata_i   (slv_rdata_i),
    .slv_ready_i   (slv_ready_i)
`ifdef IOMEM_CTRL_ERRLOG_EN
    ,
    .err_addr_o    (err_addr_o),
    .err_cnt_o     (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Slave model: ready rises once a slot has been selected for more than wait_n cycles.
  logic [31:0] slot_dat  [NUM_SLV];
  int          wait_n    [NUM_SLV];
  logic        never     [NUM_SLV];
  logic        force_rdy [NUM_SLV];
  int          sel_cnt   [NUM_SLV] = '{default: 0};

  always @(negedge clk_i) begin
    for (int k = 0; k < NUM_SLV; k++) sel_cnt[k] <= slv_sel_o[k] ? sel_cnt[k] + 1 : 0;
  end

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_slv
    assign slv_ready_i[k] = force_rdy[k] | (slv_sel_o[k] & ~never[k] & (sel_cnt[k] > wait_n[k]));
    assign slv_rdata_i[32*k +: 32] = slot_dat[k];
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one CPU request, wait (bounded) for completion, then drop valid like the CPU does.
  task automatic do_access(input string nm, input logic [31:0] a, input logic [3:0] ws,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output int sel_cyc, output int we_cyc, output logic [NUM_SLV-1:0] sel_seen,
                           output logic [7:0] sa, output logic [3:0] sws, output logic [31:0] swd);
    int bad_rd;
    int bad_sel;
    bad_rd = 0; bad_sel = 0;
    lat = 0; rd = '0; sel_cyc = 0; we_cyc = 0; sel_seen = '0; sa = '0; sws = '0; swd = '0;
    iomem_valid_i = 1'b1;
    iomem_addr_i  = a;
    iomem_wstrb_i = ws;
    iomem_wdata_i = wd;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (!$onehot0(slv_sel_o)) bad_sel++;
      if (slv_sel_o != '0) begin
        sel_cyc++;
        sel_seen = sel_seen | slv_sel_o;
        if (slv_we_o) we_cyc++;
        sa = slv_addr_o; sws = slv_wstrb_o; swd = slv_wdata_o;
      end
      if (iomem_ready_o) begin
        lat = i;
        rd  = iomem_rdata_o;
        break;
      end else if (iomem_rdata_o != 32'd0) begin
        bad_rd++;
      end
    end
    chk({nm, "/completed"}, 32'(lat != 0), 32'd1);
    iomem_valid_i = 1'b0;
    iomem_wstrb_i = 4'd0;
    tick();
    chk({nm, "/ready_one_cycle"}, 32'(iomem_ready_o), 32'd0);
    chk({nm, "/rdata_zero_after"}, iomem_rdata_o, 32'd0);
    chk({nm, "/rdata_zero_while_busy"}, 32'(bad_rd), 32'd0);
    chk({nm, "/sel_onehot"}, 32'(bad_sel), 32'd0);
  endtask

  int               lat, sel_cyc, we_cyc, rdy_seen;
  logic [31:0]      rd, swd;
  logic [NUM_SLV-1:0] sel_seen;
  logic [7:0]       sa;
  logic [3:0]       sws;

  initial begin
    slot_dat = '{32'hCAFE_0000, 32'h1234_5678, 32'h2222_2222, 32'h3333_3333};
    wait_n    = '{0, 0, 0, 0};
    never     = '{1'b0, 1'b0, 1'b0, 1'b0};
    force_rdy = '{1'b0, 1'b0, 1'b0, 1'b0};
    rst_i = 1'b1;
    iomem_valid_i = 1'b0;
    iomem_wstrb_i = 4'd0;
    iomem_addr_i  = 32'd0;
    iomem_wdata_i = 32'd0;
    repeat (3) tick();

    chk("rst/ready", 32'(iomem_ready_o), 32'd0);
    chk("rst/rdata", iomem_rdata_o, 32'd0);
    chk("rst/sel", 32'(slv_sel_o), 32'd0);
    chk("rst/we_re", 32'({slv_we_o, slv_re_o}), 32'd0);
`ifdef IOMEM_CTRL_ERRLOG_EN
    chk("rst/err_cnt", 32'(err_cnt_o), 32'd0);
`endif
    rst_i = 1'b0;
    tick();

    // Hit read, slot1 ready immediately.
    do_access("rd_slot1", 32'h0300_0100, 4'b0000, 32'd0, lat, rd, sel_cyc, we_cyc, sel_seen, sa, sws, swd);
    chk("rd_slot1/latency", 32'(lat), 32'd2);
    chk("rd_slot1/rdata", rd, 32'h1234_5678);
    chk("rd_slot1/sel_cycles", 32'(sel_cyc), 32'd1);
    chk("rd_slot1/sel", 32'(sel_seen), 32'b0010);

    // Hit write, slot2 ready after 3 wait cycles.
    wait_n[2] = 3;
    do_access("wr_slot2", 32'h0300_0204, 4'b0011, 32'hA5A5_0F0F, lat, rd, sel_cyc, we_cyc, sel_seen, sa, sws, swd);
    chk("wr_slot2/latency", 32'(lat), 32'd5);
    chk("wr_slot2/rdata", rd, 32'd0);
    chk("wr_slot2/sel_cycles", 32'(sel_cyc), 32'd4);
    chk("wr_slot2/we_cycles", 32'(we_cyc), 32'd4);
    chk("wr_slot2/sel", 32'(sel_seen), 32'b0100);
    chk("wr_slot2/slv_addr", 32'(sa), 32'h04);
    chk("wr_slot2/slv_wstrb", 32'(sws), 32'b0011);
    chk("wr_slot2/slv_wdata", swd, 32'hA5A5_0F0F);
    wait_n[2] = 0;

    // Window past NUM_SLV inside the region: unmapped read.
    do_access("unmap_rd", 32'h0300_0400, 4'b0000, 32'd0, lat, rd, sel_cyc, we_cyc, sel_seen, sa, sws, swd);
    chk("unmap_rd/latency", 32'(lat), 32'd1);
    chk("unmap_rd/rdata", rd, 32'hFFFF_FFFF);
    chk("unmap_rd/sel_cycles", 32'(sel_cyc), 32'd0);
`ifdef IOMEM_CTRL_ERRLOG_EN
    chk("unmap_rd/err_addr", err_addr_o, 32'h0300_0400);
    chk("unmap_rd/err_cnt", 32'(err_cnt_o), 32'd1);
`endif

    // Outside the region entirely: unmapped write is dropped and returns 0.
    do_access("unmap_wr", 32'h0500_0100, 4'b1111, 32'h0BAD_F00D, lat, rd, sel_cyc, we_cyc, sel_seen, sa, sws, swd);
    chk("unmap_wr/latency", 32'(lat), 32'd1);
    chk("unmap_wr/rdata", rd, 32'd0);
    chk("unmap_wr/sel_cycles", 32'(sel_cyc), 32'd0);
`ifdef IOMEM_CTRL_ERRLOG_EN
    chk("unmap_wr/err_cnt", 32'(err_cnt_o), 32'd2);
`endif

    // Slot3 never answers: timeout after 64 ACCESS cycles.
    never[3] = 1'b1;
    do_access("tmo_slot3", 32'h0300_0300, 4'b0000, 32'd0, lat, rd, sel_cyc, we_cyc, sel_seen, sa, sws, swd);
    chk("tmo_slot3/latency", 32'(lat), 32'd65);
    chk("tmo_slot3/rdata", rd, 32'hDEAD_BEEF);
    chk("tmo_slot3/sel_cycles", 32'(sel_cyc), 32'd64);
    chk("tmo_slot3/sel", 32'(sel_seen), 32'b1000);
`ifdef IOMEM_CTRL_ERRLOG_EN
    chk("tmo_slot3/err_addr", err_addr_o, 32'h0300_0300);
    chk("tmo_slot3/err_cnt", 32'(err_cnt_o), 32'd3);
`endif

    // Slot0 ready stuck high must not complete an access to slot1.
    force_rdy[0] = 1'b1;
    wait_n[1] = 5;
    do_access("foreign_rdy", 32'h0300_0108, 4'b0000, 32'd0, lat, rd, sel_cyc, we_cyc, sel_seen, sa, sws, swd);
    chk("foreign_rdy/latency", 32'(lat), 32'd7);
    chk("foreign_rdy/rdata", rd, 32'h1234_5678);
    chk("foreign_rdy/sel", 32'(sel_seen), 32'b0010);
    force_rdy[0] = 1'b0;
    wait_n[1] = 0;

    // Reset pulse in the 10th ACCESS cycle of a stalled read to slot2.
    never[2] = 1'b1;
    iomem_valid_i = 1'b1;
    iomem_addr_i  = 32'h0300_0210;
    iomem_wstrb_i = 4'b0000;
    rdy_seen = 0;
    repeat (10) begin
      tick();
      if (iomem_ready_o) rdy_seen++;
    end
    chk("rst_mid/sel_before", 32'(slv_sel_o), 32'b0100);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    iomem_valid_i = 1'b0;
    chk("rst_mid/ready", 32'(iomem_ready_o), 32'd0);
    chk("rst_mid/rdata", iomem_rdata_o, 32'd0);
    chk("rst_mid/sel", 32'(slv_sel_o), 32'd0);
    chk("rst_mid/we_re", 32'({slv_we_o, slv_re_o}), 32'd0);
    chk("rst_mid/slv_addr", 32'(slv_addr_o), 32'd0);
    chk("rst_mid/slv_wstrb_wdata", slv_wdata_o | 32'(slv_wstrb_o), 32'd0);
`ifdef IOMEM_CTRL_ERRLOG_EN
    chk("rst_mid/err_cnt", 32'(err_cnt_o), 32'd0);
`endif
    repeat (5) begin
      tick();
      if (iomem_ready_o) rdy_seen++;
    end
    chk("rst_mid/no_ready_pulse", 32'(rdy_seen), 32'd0);
    never[2] = 1'b0;

    do_access("after_rst", 32'h0300_0008, 4'b0000, 32'd0, lat, rd, sel_cyc, we_cyc, sel_seen, sa, sws, swd);
    chk("after_rst/latency", 32'(lat), 32'd2);
    chk("after_rst/rdata", rd, 32'hCAFE_0000);
    chk("after_rst/sel", 32'(sel_seen), 32'b0001);
    chk("after_rst/slv_addr", 32'(sa), 32'h08);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/iomem_ctrl.md
Name: iomem_ctrl

Overview:
- Sequences every PicoSoC iomem transaction onto up to NUM_SLV peripheral slots: GPIO, SimpleRNG, user RAM and future blocks.
- Replaces the ad-hoc if/else decode at the top level with one registered state machine.
- Provides deterministic address decode: one slot per 256-byte window, no overlapping windows.
- Handles per-slot ready/wait, returns a fixed value for unmapped addresses, and aborts hung slaves with a timeout.
- Sits between picosoc iomem_* and the peripheral instances in the top level.

Parameters:
- NUM_SLV, 4, number of slots; range 1..16.
- BASE_ADDR, 32'h0300_0000, region base; only bits [31:12] are compared.
- TIMEOUT_CYC, 64, cycles in ACCESS before abort; minimum 2.
- UNMAP_DATA, 32'hFFFF_FFFF, read data returned for an unmapped address.
- TMO_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- iomem_valid_i  in  1  CPU request.
- iomem_ready_o  out  1  one-cycle completion pulse.
- iomem_wstrb_i  in  4  byte strobes; 0 means read.
- iomem_addr_i  in  32  byte address.
- iomem_wdata_i  in  32  write data.
- iomem_rdata_o  out  32  read data; valid while iomem_ready_o is high.
- slv_sel_o  out  NUM_SLV  one-hot slot select.
- slv_we_o  out  1  write access (|wstrb).
- slv_re_o  out  1  read access.
- slv_wstrb_o  out  4  latched strobes.
- slv_addr_o  out  8  latched addr[7:0].
- slv_wdata_o  out  32  latched write data.
- slv_rdata_i  in  32*NUM_SLV  flat read buses; slot k occupies bits [32k+31:32k].
- slv_ready_i  in  NUM_SLV  per-slot ready, combinational, sampled while selected.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, timeout counter 0. Reset asserted mid-ACCESS aborts the access; no ready pulse is issued for it.
- Decode:
  - Hit: addr[31:12]==BASE_ADDR[31:12] and addr[11:8] < NUM_SLV.
  - slot = addr[11:8].
  - Everything else is unmapped.
- IDLE:
  - On iomem_valid_i=1, latch addr, wdata, wstrb and slot.
  - Hit → ACCESS.
  - Unmapped → RESP with rdata = UNMAP_DATA for reads, 0 for writes. Unmapped writes are dropped.
- ACCESS:
  - slv_sel_o[slot], slv_we_o/slv_re_o, slv_addr_o, slv_wdata_o and slv_wstrb_o are held as level signals, driven from registers.
  - If slv_ready_i[slot]=1: capture its slv_rdata slice (0 for writes) → RESP. Ready bits of other slots are ignored.
  - Otherwise the counter increments. When counter == TIMEOUT_CYC-1 with no ready → RESP with rdata = TMO_DATA for reads, 0 for writes.
  - The counter clears on leaving ACCESS.
- RESP:
  - iomem_ready_o=1 for exactly one cycle; iomem_rdata_o holds the captured value.
  - slv_sel_o, slv_we_o and slv_re_o are 0.
  - Next state is IDLE.
- Latency:
  - Slave ready in the first ACCESS cycle: iomem_ready_o two cycles after valid is sampled.
  - Unmapped: one cycle.
  - Worst case: TIMEOUT_CYC+1 cycles.
- Handshake: the CPU holds valid until ready and drops it the cycle after. IDLE samples valid only when iomem_ready_o=0, so no access is issued twice.
- iomem_rdata_o is 0 whenever iomem_ready_o=0.
- Requests are strictly serialised; at most one slot is ever selected.

Optional Feature:
- Macro: IOMEM_CTRL_ERRLOG_EN.
- When defined, adds two outputs:
  - err_addr_o (32): address of the most recent unmapped or timed-out access.
  - err_cnt_o (8): saturating error count, sticks at 255.
- Both clear on rst_i.
- A timeout and an unmapped access count the same; each transaction adds at most 1.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package iomem_ctrl_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - slot index width localparam (4);
  - default UNMAP_DATA and TMO_DATA constants;
  - the slot-number constants SLOT_GPIO=0, SLOT_RNG=1, SLOT_RAM=2.
- Sub-module iomem_decode: combinational hit and slot computation from address, BASE_ADDR and NUM_SLV.
- The FSM, counter and error log stay in iomem_ctrl.

Test Plan:
- Read 0x0300_0100, slot1 holds ready high with rdata 0x1234_5678 → sel_o=4'b0010 for one cycle, iomem_ready_o two cycles after valid, rdata 0x1234_5678.
- Write 0x0300_0204, wstrb 4'b0011, wdata 0xA5A5_0F0F, slot2 ready after 3 wait cycles → slv_addr_o=0x04, slv_wstrb_o=0011, slv_we_o=1 held for 4 cycles; response rdata 0.
- Read 0x0300_0400 with NUM_SLV=4 → no sel, ready one cycle after valid, rdata 0xFFFF_FFFF; with IOMEM_CTRL_ERRLOG_EN: err_addr_o=0x0300_0400, err_cnt_o=1.
- Read slot3, which never asserts ready, TIMEOUT_CYC=64 → sel_o[3] high 64 cycles, then ready with rdata 0xDEAD_BEEF.
- rst_i pulsed for 1 cycle during the 10th ACCESS cycle → all outputs 0 next cycle, no ready pulse; a following read to slot0 completes normally.
- slot0 ready held permanently high while slot1 is accessed → slot0 ready ignored, completion waits for slot1 ready.
